ysyx_20020207_rf_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the core's 32-entry integer register file. It shares the file's single write port between the EXU and LSU writeback sources using a round-robin grant. It tracks destination registers with outstanding writes so IDU can detect RAW/WAW hazards. It sits between the EXU/LSU writeback paths and the register file write port; its registered write outputs drive the file's write enable, address and data directly.

---
 rtl/ysyx_20020207_rf_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_ysyx_20020207_rf_wb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_20020207_rf_wb_arbiter.sv
// ysyx_20020207_rf_wb_arbiter
// Shares the register file's single write port between the EXU and LSU
// writeback paths with a round-robin grant. It also keeps a busy scoreboard
// of destinations with outstanding writes, which IDU uses for hazard checks.
// Optional feature macro: RF_WB_FORWARD_EN adds a bypass of the registered
// write so that IDU can read a value in the same cycle it is written.
module ysyx_20020207_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  hazard1,
    output logic                  hazard2,
    input  logic                  exu_valid,
    input  logic [ADDR_WIDTH-1:0] exu_waddr,
    input  logic [DATA_WIDTH-1:0] exu_wdata,
    output logic                  exu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_ready,
`ifdef RF_WB_FORWARD_EN
    output logic                  fwd1_valid,
    output logic                  fwd2_valid,
    output logic [DATA_WIDTH-1:0] fwd1_data,
    output logic [DATA_WIDTH-1:0] fwd2_data,
`endif
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_err
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_nxt;
    logic                  rr_exu;      // 1: EXU wins the next contention
    logic                  issue_fire;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] g_waddr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic                  g_write;

    // Issue acceptance: x0 never conflicts, otherwise stall on a pending write.
    always_comb begin
        issue_ready = !issue_valid || (issue_rd == '0) || !busy[issue_rd];
        issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
    end

    // Round-robin pointer: only moves when both sides competed for the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_exu <= 1'b1;
        end else if (exu_valid && lsu_valid) begin
            rr_exu <= !exu_ready;
        end
    end

    // Grant selection and mux of the winning request.
    always_comb begin
        exu_ready = exu_valid && (!lsu_valid || rr_exu);
        lsu_ready = lsu_valid && (!exu_valid || !rr_exu);
        grant     = exu_ready || lsu_ready;
        g_waddr   = exu_ready ? exu_waddr : lsu_waddr;
        g_wdata   = exu_ready ? exu_wdata : lsu_wdata;
        g_write   = grant && (g_waddr != '0);
    end

    // Scoreboard next state: the write in flight clears, a new issue sets,
    // and the set is applied last so it wins on the same register.
    always_comb begin
        busy_nxt = busy;
        if (rf_wen) begin
            busy_nxt[rf_waddr] = 1'b0;
        end
        if (issue_fire) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Output stage: a grant to x0 is consumed without touching the port, and
    // address/data only move on a real write so they keep the last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_err   <= 1'b0;
        end else begin
            rf_wen <= g_write;
            if (g_write) begin
                rf_waddr <= g_waddr;
                rf_wdata <= g_wdata;
                if (!busy[g_waddr]) begin
                    wb_err <= 1'b1;
                end
            end
        end
    end

`ifdef RF_WB_FORWARD_EN
    // Bypass the registered write; a forwarded source is not a hazard.
    always_comb begin
        fwd1_valid = rf_wen && (rf_waddr == raddr1) && (raddr1 != '0);
        fwd2_valid = rf_wen && (rf_waddr == raddr2) && (raddr2 != '0);
        fwd1_data  = rf_wdata;
        fwd2_data  = rf_wdata;
        hazard1    = (raddr1 != '0) && busy[raddr1] && !fwd1_valid;
        hazard2    = (raddr2 != '0) && busy[raddr2] && !fwd2_valid;
    end
`else
    // Source hazards follow the scoreboard only.
    always_comb begin
        hazard1 = (raddr1 != '0) && busy[raddr1];
        hazard2 = (raddr2 != '0) && busy[raddr2];
    end
`endif

endmodule

// File: tb/tb_ysyx_20020207_rf_wb_arbiter.sv
module tb_ysyx_20020207_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  raddr1, raddr2;
    logic        hazard1, hazard2;
    logic        exu_valid;
    logic [4:0]  exu_waddr;
    logic [31:0] exu_wdata;
    logic        exu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_err;
`ifdef RF_WB_FORWARD_EN
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    int checks   = 0;
    int failures = 0;
    logic both_seen = 1'b0;

    ysyx_20020207_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .raddr1(raddr1), .raddr2(raddr2), .hazard1(hazard1), .hazard2(hazard2),
        .exu_valid(exu_valid), .exu_waddr(exu_waddr), .exu_wdata(exu_wdata), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
`ifdef RF_WB_FORWARD_EN
        .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (exu_ready && lsu_ready) both_seen <= 1'b1;
    end

    typedef struct {
        logic        iv;
        logic [4:0]  ird, ra1, ra2;
        logic        ev;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        x_ir, x_h1, x_h2, x_er, x_lr, x_wen;
        logic [4:0]  x_wa;
        logic [31:0] x_wd;
        logic        x_err;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=0x%0h expected=0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_rd = v.ird; raddr1 = v.ra1; raddr2 = v.ra2;
        exu_valid = v.ev; exu_waddr = v.ea; exu_wdata = v.ed;
        lsu_valid = v.lv; lsu_waddr = v.la; lsu_wdata = v.ld;
    endtask

    initial begin
        vec_t idle;
        logic eh1, eh2;
        //        iv ird ra1 ra2  ev ea ed            lv la ld        ir h1 h2 er lr wen wa wd            err
        vecs[0]  = '{0, 5, 5, 0,  0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 0, 32'h0,        0};
        vecs[1]  = '{1, 5, 5, 0,  0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 0, 32'h0,        0};
        vecs[2]  = '{0, 0, 5, 0,  1, 5, 32'hDEADBEEF, 0, 0, 32'h0,    1, 1, 0, 1, 0, 0, 0, 32'h0,        0};
        vecs[3]  = '{0, 0, 5, 0,  0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0};
        vecs[4]  = '{0, 0, 5, 0,  0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0};
        vecs[5]  = '{1, 3, 3, 0,  0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0};
        vecs[6]  = '{1, 4, 3, 4,  0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0};
        vecs[7]  = '{0, 0, 3, 4,  1, 3, 32'h33,       1, 4, 32'h44,   1, 1, 1, 1, 0, 0, 5, 32'hDEADBEEF, 0};
        vecs[8]  = '{0, 0, 3, 4,  0, 0, 32'h0,        1, 4, 32'h44,   1, 1, 1, 0, 1, 1, 3, 32'h33,       0};
        vecs[9]  = '{0, 0, 3, 4,  1, 0, 32'h55,       1, 0, 32'h66,   1, 0, 1, 0, 1, 1, 4, 32'h44,       0};
        vecs[10] = '{0, 0, 3, 4,  1, 0, 32'h55,       1, 0, 32'h77,   1, 0, 0, 1, 0, 0, 4, 32'h44,       0};
        vecs[11] = '{0, 0, 0, 0,  0, 0, 32'h0,        1, 0, 32'h77,   1, 0, 0, 0, 1, 0, 4, 32'h44,       0};
        vecs[12] = '{0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 4, 32'h44,       0};
        vecs[13] = '{1, 7, 7, 0,  0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 0, 0, 0, 0, 4, 32'h44,       0};
        vecs[14] = '{1, 7, 7, 0,  0, 0, 32'h0,        0, 0, 32'h0,    0, 1, 0, 0, 0, 0, 4, 32'h44,       0};
        vecs[15] = '{1, 0, 7, 0,  0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 0, 0, 0, 0, 4, 32'h44,       0};
        vecs[16] = '{0, 0, 7, 0,  1, 9, 32'h99,       0, 0, 32'h0,    1, 1, 0, 1, 0, 0, 4, 32'h44,       0};
        vecs[17] = '{1, 9, 7, 0,  0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 0, 0, 0, 1, 9, 32'h99,       1};
        vecs[18] = '{0, 0, 7, 9,  1, 7, 32'h77,       0, 0, 32'h0,    1, 1, 1, 1, 0, 0, 9, 32'h99,       1};
        vecs[19] = '{0, 0, 7, 9,  0, 0, 32'h0,        0, 0, 32'h0,    1, 1, 1, 0, 0, 1, 7, 32'h77,       1};
        vecs[20] = '{0, 0, 7, 9,  0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 1, 0, 0, 0, 7, 32'h77,       1};
        idle = vecs[12];

        rst = 1'b1;
        drive(idle);
        #1;
        chk("reset_rf_wen", -1, {31'b0, rf_wen}, 32'd0);
        chk("reset_wb_err", -1, {31'b0, wb_err}, 32'd0);
        chk("reset_rf_waddr", -1, {27'b0, rf_waddr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            eh1 = vecs[i].x_h1;
            eh2 = vecs[i].x_h2;
`ifdef RF_WB_FORWARD_EN
            if (vecs[i].x_wen && vecs[i].x_wa == vecs[i].ra1 && vecs[i].ra1 != 5'd0) begin
                eh1 = 1'b0;
                chk("fwd1_valid", i, {31'b0, fwd1_valid}, 32'd1);
                chk("fwd1_data", i, fwd1_data, vecs[i].x_wd);
            end
            if (vecs[i].x_wen && vecs[i].x_wa == vecs[i].ra2 && vecs[i].ra2 != 5'd0) begin
                eh2 = 1'b0;
                chk("fwd2_valid", i, {31'b0, fwd2_valid}, 32'd1);
            end
`endif
            chk("issue_ready", i, {31'b0, issue_ready}, {31'b0, vecs[i].x_ir});
            chk("hazard1", i, {31'b0, hazard1}, {31'b0, eh1});
            chk("hazard2", i, {31'b0, hazard2}, {31'b0, eh2});
            chk("exu_ready", i, {31'b0, exu_ready}, {31'b0, vecs[i].x_er});
            chk("lsu_ready", i, {31'b0, lsu_ready}, {31'b0, vecs[i].x_lr});
            chk("rf_wen", i, {31'b0, rf_wen}, {31'b0, vecs[i].x_wen});
            chk("rf_waddr", i, {27'b0, rf_waddr}, {27'b0, vecs[i].x_wa});
            chk("rf_wdata", i, rf_wdata, vecs[i].x_wd);
            chk("wb_err", i, {31'b0, wb_err}, {31'b0, vecs[i].x_err});
        end

        // Reset in the middle of a write: outputs and scoreboard clear at once.
        @(negedge clk);
        drive(idle);
        issue_valid = 1'b1; issue_rd = 5'd10;
        @(negedge clk);
        drive(idle);
        raddr1 = 5'd10;
        exu_valid = 1'b1; exu_waddr = 5'd11; exu_wdata = 32'hBB;
        #1;
        chk("mid_hazard_before", 100, {31'b0, hazard1}, 32'd1);
        @(negedge clk);
        exu_valid = 1'b0;
        #1;
        chk("mid_wen_before", 101, {31'b0, rf_wen}, 32'd1);
        chk("mid_waddr_before", 101, {27'b0, rf_waddr}, 32'd11);
        rst = 1'b1;
        #1;
        chk("mid_rst_wen", 102, {31'b0, rf_wen}, 32'd0);
        chk("mid_rst_hazard", 102, {31'b0, hazard1}, 32'd0);
        chk("mid_rst_waddr", 102, {27'b0, rf_waddr}, 32'd0);
        chk("mid_rst_wb_err", 102, {31'b0, wb_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        chk("post_rst_issue_ready", 103, {31'b0, issue_ready}, 32'd1);

        // After reset the pointer favours EXU again.
        @(negedge clk);
        drive(idle);
        exu_valid = 1'b1; exu_waddr = 5'd0;
        lsu_valid = 1'b1; lsu_waddr = 5'd0;
        #1;
        chk("post_rst_rr_exu", 104, {31'b0, exu_ready}, 32'd1);
        chk("post_rst_rr_lsu", 104, {31'b0, lsu_ready}, 32'd0);
        @(negedge clk);
        drive(idle);

        chk("never_both_ready", 105, {31'b0, both_seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
